stopwatch_core: RTL

Parametrised stopwatch/timer engine that replaces the fixed divide-by-20 slow clock and single-counter timer. It runs on the system clock with an internal tick enable, so no derived clock is used. It counts minutes/seconds/centiseconds in BCD, up or down from a loaded preset, and stores lap times in a small buffer. It sits between the button conditioning logic and the 7-segment/LCD formatters.

---
 rtl/stopwatch_pkg.sv | 25 ++
 rtl/bcd_time_counter.sv | 42 ++++
 rtl/stopwatch_core.sv | 129 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch engine: FSM states and BCD time digits.
// Digit order inside time_bcd_t is {m1,m0,s1,s0,c1,c0}, index 5 down to 0.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } sw_state_t;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [5:0] time_bcd_t;

  localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t DIGIT_MAX    = 4'd9;
  localparam int         SEC_TENS_IDX = 3;
  localparam time_bcd_t  TIME_MAX     = 24'h995999;

  // Highest legal value of the digit at position idx before it wraps.
  function automatic bcd_digit_t digit_limit(input int idx);
    return (idx == SEC_TENS_IDX) ? SEC_TENS_MAX : DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Combinational +/-1 centisecond step over a 6-digit BCD time, with range flags.
// Latency: zero cycles (pure combinational). Backpressure: none, no handshake.
module bcd_time_counter
  import stopwatch_pkg::*;
(
  input  time_bcd_t cur,
  input  logic      down,
  output time_bcd_t nxt,
  output logic      at_max,
  output logic      at_zero
);

  logic ripple;

  always_comb begin
    nxt    = cur;
    ripple = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (ripple) begin
        if (down) begin
          if (cur[i] == 4'd0) begin
            nxt[i] = digit_limit(i);
          end else begin
            nxt[i] = cur[i] - 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (cur[i] == digit_limit(i)) begin
            nxt[i] = 4'd0;
          end else begin
            nxt[i] = cur[i] + 4'd1;
            ripple = 1'b0;
          end
        end
      end
    end
  end

  assign at_max  = (cur == TIME_MAX);
  assign at_zero = (cur == '0);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch/timer engine: run/pause FSM, tick divider, BCD time register, lap buffer.
// Latency: time updates the edge after a tick; lap_bcd is one cycle behind lap_sel. Backpressure: none, pulses acted on same cycle.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int LAP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_start,
  input  logic                           btn_lap,
  input  logic                           btn_clear,
  input  logic                           mode_down,
  input  logic                           preset_load,
  input  logic [23:0]                    preset_bcd,
  input  logic [$clog2(LAP_DEPTH)-1:0]   lap_sel,
  output logic [23:0]                    time_bcd,
  output logic [23:0]                    lap_bcd,
  output logic [$clog2(LAP_DEPTH):0]     lap_count,
  output logic                           lap_full,
  output logic                           running,
  output logic                           expired
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAP_LIMIT = CW'(LAP_DEPTH);

  sw_state_t        state, state_n;
  time_bcd_t        cur_time, cnt_nxt;
  logic             cnt_at_max, cnt_at_zero;
  logic             dir_down;
  logic [DIV_W-1:0] div_cnt;
  logic [CW-1:0]    lap_cnt;
  time_bcd_t        lap_ram [LAP_DEPTH];
  logic             tick, tick_hold, lap_we, lap_store;

  bcd_time_counter u_cnt (
    .cur     (cur_time),
    .down    (dir_down),
    .nxt     (cnt_nxt),
    .at_max  (cnt_at_max),
    .at_zero (cnt_at_zero)
  );

  assign tick      = (state == RUN) && (div_cnt == DIV_LAST);
  // A tick at the end of the range holds the value rather than wrapping.
  assign tick_hold = dir_down ? cnt_at_zero : cnt_at_max;
  assign lap_we    = (state == RUN) && btn_lap && !btn_clear && !rst;
  assign lap_store = lap_we && (lap_cnt != LAP_LIMIT);

  always_comb begin
    state_n = state;
    if (btn_clear) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (btn_start) state_n = (mode_down && cnt_at_zero) ? EXPIRED : RUN;
        RUN: begin
          if (btn_start) state_n = PAUSE;
          else if (tick && (tick_hold || (dir_down && cnt_nxt == '0))) state_n = EXPIRED;
        end
        // A pause landing on 00:00.00 while counting down must not borrow on resume.
        PAUSE:   if (btn_start) state_n = (dir_down && cnt_at_zero) ? EXPIRED : RUN;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      running  <= 1'b0;
      expired  <= 1'b0;
      dir_down <= 1'b0;
    end else begin
      state   <= state_n;
      running <= (state_n == RUN);
      expired <= (state_n == EXPIRED);
      if (state == IDLE && btn_start && !btn_clear) dir_down <= mode_down;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || btn_clear) begin
      cur_time <= '0;
    end else if ((state == IDLE || state == PAUSE) && !btn_start && preset_load) begin
      cur_time <= time_bcd_t'(preset_bcd);
    end else if (tick && !tick_hold) begin
      cur_time <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || btn_clear) begin
      div_cnt <= '0;
    end else if (state == RUN) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || btn_clear) begin
      lap_cnt  <= '0;
      lap_full <= 1'b0;
    end else if (lap_we) begin
      if (lap_cnt == LAP_LIMIT) lap_full <= 1'b1;
      else                      lap_cnt  <= lap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (lap_store) lap_ram[lap_cnt[AW-1:0]] <= cur_time;
  end

  always_ff @(posedge clk) begin
    if (rst) lap_bcd <= '0;
    else     lap_bcd <= lap_ram[lap_sel];
  end

  assign time_bcd  = cur_time;
  assign lap_count = lap_cnt;

endmodule
